// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: bubble instruction, base opcodes, IF/ID payload and IF/ID FSM states.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } if_id_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } if_id_state_e;

endpackage

// File: rtl/if_id_slot.sv
// One IF/ID holding register: valid bit plus payload. Clear wins over load and
// returns the payload to a NOP bubble with zero PCs.
module if_id_slot
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR_P = riscv_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  logic   i_clear,
  input  if_id_t i_data,
  output logic   o_valid,
  output if_id_t o_data
);

  if_id_t w_bubble;
  assign w_bubble = '{instr: NOP_INSTR_P, pc: '0, pcplus4: '0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= w_bubble;
    end else if (i_clear) begin
      o_valid <= 1'b0;
      o_data  <= w_bubble;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register with 2-entry skid buffer (main = output, skid = overflow).
// Optional performance counters enabled by defining IF_ID_PERF_EN.
module if_id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  input  logic [31:0]     f_instr,
  input  logic [XLEN-1:0] f_pc,
  input  logic [XLEN-1:0] f_pcplus4,
  output logic            f_ready,
  input  logic            flush,
  input  logic            d_ready,
  output logic            d_valid,
  output logic [31:0]     d_instr,
  output logic [6:0]      d_op,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_pcplus4,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  if_id_state_e r_state, w_next_state;

  if_id_t w_f_data, w_main_d, w_main_q, w_skid_q;
  logic   w_main_valid, w_skid_valid;
  logic   w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  logic   w_f_fire, w_d_fire;

  assign w_f_data = '{instr: f_instr, pc: f_pc, pcplus4: f_pcplus4};

  // f_ready depends only on registered state, never on d_ready.
  assign f_ready  = !w_skid_valid;
  assign d_valid  = w_main_valid;
  assign w_f_fire = f_valid && f_ready;
  assign w_d_fire = d_valid && d_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    w_main_d     = w_f_data;
    if (flush) begin
      w_next_state = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_f_fire) begin
            w_main_load  = 1'b1;
            w_next_state = FULL;
          end
        end
        FULL: begin
          if (w_f_fire && w_d_fire) begin
            w_main_load = 1'b1;
          end else if (w_d_fire) begin
            w_main_clear = 1'b1;
            w_next_state = EMPTY;
          end else if (w_f_fire) begin
            w_skid_load  = 1'b1;
            w_next_state = SKID;
          end
        end
        SKID: begin
          if (w_d_fire) begin
            w_main_d     = w_skid_q;
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
            w_next_state = FULL;
          end
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  if_id_slot #(.NOP_INSTR_P(NOP_INSTR)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_d),
    .o_valid (w_main_valid),
    .o_data  (w_main_q)
  );

  if_id_slot #(.NOP_INSTR_P(NOP_INSTR)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_f_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_q)
  );

  assign d_instr   = w_main_q.instr;
  assign d_op      = w_main_q.instr[6:0];
  assign d_pc      = w_main_q.pc;
  assign d_pcplus4 = w_main_q.pcplus4;

`ifdef IF_ID_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (d_valid && !d_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)               r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (handshake, skid, flush, reset, counters).
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic [31:0] f_pcplus4;
  logic        f_ready;
  logic        flush;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [6:0]  d_op;
  logic [31:0] d_pc;
  logic [31:0] d_pcplus4;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  if_id_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_valid   (f_valid),
    .f_instr   (f_instr),
    .f_pc      (f_pc),
    .f_pcplus4 (f_pcplus4),
    .f_ready   (f_ready),
    .flush     (flush),
    .d_ready   (d_ready),
    .d_valid   (d_valid),
    .d_instr   (d_instr),
    .d_op      (d_op),
    .d_pc      (d_pc),
    .d_pcplus4 (d_pcplus4),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    f_valid   = v;
    f_instr   = instr;
    f_pc      = pc;
    f_pcplus4 = pc + 32'd4;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    d_ready = 1'b1;
    drive_f(1'b0, 32'h0, 32'h0);
    #12;
    chk("rst_dvalid", {31'b0, d_valid}, 32'd0);
    chk("rst_dinstr", d_instr, 32'h13);
    chk("rst_fready", {31'b0, f_ready}, 32'd1);
    chk("rst_stall",  stall_cnt, 32'd0);
    chk("rst_flush",  flush_cnt, 32'd0);
    rst_n = 1'b1;

    // Streaming, 1-cycle latency
    d_ready = 1'b1;
    drive_f(1'b1, 32'h0000_0033, 32'h0);
    tick(); chk("str_pc0", d_pc, 32'h0); chk("str_v0", {31'b0, d_valid}, 32'd1);
    chk("str_p4_0", d_pcplus4, 32'h4);
    drive_f(1'b1, 32'h0000_0033, 32'h4);
    tick(); chk("str_pc4", d_pc, 32'h4);
    drive_f(1'b1, 32'h0000_0033, 32'h8);
    tick(); chk("str_pc8", d_pc, 32'h8);
    drive_f(1'b0, 32'h0, 32'h0);
    tick(); chk("str_drain", {31'b0, d_valid}, 32'd0);
    chk("str_drain_nop", d_instr, 32'h13);

    // Stall into skid, then release
    d_ready = 1'b0;
    drive_f(1'b1, 32'h0000_0003, 32'h10);
    tick(); chk("stl_pc10", d_pc, 32'h10);
    drive_f(1'b1, 32'h0000_0023, 32'h14);
    tick(); chk("stl_fready", {31'b0, f_ready}, 32'd0);
    chk("stl_hold", d_pc, 32'h10);
    chk("stl_hold_instr", d_instr, 32'h0000_0003);
    drive_f(1'b0, 32'h0, 32'h0);
    d_ready = 1'b1;
    tick(); chk("stl_pc14", d_pc, 32'h14); chk("stl_instr14", d_instr, 32'h0000_0023);
    chk("stl_fready1", {31'b0, f_ready}, 32'd1);
    tick(); chk("stl_empty", {31'b0, d_valid}, 32'd0);

    // Flush while in SKID with a fetch offered
    d_ready = 1'b0;
    drive_f(1'b1, 32'h0000_0033, 32'h18);
    tick();
    drive_f(1'b1, 32'h0000_0033, 32'h1c);
    tick(); chk("fl_skid", {31'b0, f_ready}, 32'd0);
    drive_f(1'b1, 32'h0000_0033, 32'h20);
    flush = 1'b1;
    tick(); chk("fl_dvalid", {31'b0, d_valid}, 32'd0);
    chk("fl_dop", {25'b0, d_op}, 32'h13);
    chk("fl_fready", {31'b0, f_ready}, 32'd1);
    flush = 1'b0;
    drive_f(1'b0, 32'h0, 32'h0);
    tick(); chk("fl_no20_v", {31'b0, d_valid}, 32'd0);
    chk("fl_no20_pc", d_pc, 32'h0);

    // Opcode pass-through
    d_ready = 1'b1;
    drive_f(1'b1, 32'h0000_006F, 32'h40);
    tick(); chk("op_jal", {25'b0, d_op}, 32'h6F);
    drive_f(1'b1, 32'h0000_8067, 32'h44);
    tick(); chk("op_jalr", {25'b0, d_op}, 32'h67);
    chk("op_jalr_instr", d_instr, 32'h0000_8067);
    drive_f(1'b0, 32'h0, 32'h0);
    tick();

    // Async reset while in SKID
    d_ready = 1'b0;
    drive_f(1'b1, 32'h0000_0033, 32'h50);
    tick();
    drive_f(1'b1, 32'h0000_0033, 32'h54);
    tick(); chk("ar_skid", {31'b0, f_ready}, 32'd0);
    drive_f(1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("ar_dvalid", {31'b0, d_valid}, 32'd0);
    chk("ar_dinstr", d_instr, 32'h13);
    chk("ar_fready", {31'b0, f_ready}, 32'd1);
    chk("ar_dpc", d_pc, 32'h0);
    #2;
    rst_n = 1'b1;

    // Counters: 3 stall cycles, then one flush coinciding with a consume
    d_ready = 1'b0;
    drive_f(1'b1, 32'h0000_0033, 32'h60);
    tick();
    drive_f(1'b0, 32'h0, 32'h0);
    tick(); tick(); tick();
    d_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
`ifdef IF_ID_PERF_EN
    chk("perf_stall", stall_cnt, 32'd3);
    chk("perf_flush", flush_cnt, 32'd1);
`else
    chk("perf_stall", stall_cnt, 32'd0);
    chk("perf_flush", flush_cnt, 32'd0);
`endif
    chk("perf_empty", {31'b0, d_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
